// File: rtl/dma_desc_scheduler_pkg.sv
// Shared types and constants for the DMA descriptor scheduler.
package dma_sched_pkg;

    localparam int unsigned DESC_ID_W   = 8;
    localparam int unsigned DESC_CTRL_W = 21;
    localparam int unsigned CNT_W       = 4;

    // Bit offsets of the descriptor control fields within desc_ctrl_t
    localparam int unsigned SEL_LSB    = 0;
    localparam int unsigned BURST_LSB  = 4;
    localparam int unsigned SIZE_LSB   = 6;
    localparam int unsigned LEN_LSB    = 9;
    localparam int unsigned CH_SEL_LSB = 17;
    localparam int unsigned WRITE_LSB  = 19;
    localparam int unsigned ENDIAN_LSB = 20;

    typedef struct packed {
        logic       endian;
        logic       write;
        logic [1:0] ch_sel;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic [3:0] sel;
    } desc_ctrl_t;

endpackage

// File: rtl/dma_desc_scheduler_if.sv
// Requester, descriptor-read and completion signals of the descriptor scheduler.
interface dma_desc_scheduler_if
    import dma_sched_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_WIDTH = 16
) ();
    logic [N_REQ-1:0]      i_req_valid;
    logic [N_REQ-1:0]      o_req_ready;
    desc_ctrl_t            i_req_ctrl     [N_REQ];
    logic [ADDR_WIDTH-1:0] i_req_dma_addr [N_REQ];
    logic [ADDR_WIDTH-1:0] i_req_mem_addr [N_REQ];

    logic                  o_desc_rready;
    logic                  i_desc_rd;
    logic                  o_desc_endian;
    logic                  o_desc_write;
    logic [1:0]            o_desc_ch_sel;
    logic [7:0]            o_desc_len;
    logic [2:0]            o_desc_size;
    logic [1:0]            o_desc_burst;
    logic [3:0]            o_desc_sel;
    logic [7:0]            o_desc_id;
    logic [ADDR_WIDTH-1:0] o_desc_dma_addr;
    logic [ADDR_WIDTH-1:0] o_desc_mem_addr;

    logic                  i_resp_wr;
    logic [7:0]            i_resp_desc_id;
    logic [1:0]            i_resp_ch_sel;
    logic                  o_resp_wready;
    logic [N_REQ-1:0]      o_cpl_valid;
    logic [7:0]            o_cpl_id;
    logic [1:0]            o_cpl_ch_sel;
    logic                  o_err;

    modport slave (
        input  i_req_valid, i_req_ctrl, i_req_dma_addr, i_req_mem_addr,
        input  i_desc_rd, i_resp_wr, i_resp_desc_id, i_resp_ch_sel,
        output o_req_ready, o_desc_rready, o_desc_endian, o_desc_write,
        output o_desc_ch_sel, o_desc_len, o_desc_size, o_desc_burst, o_desc_sel,
        output o_desc_id, o_desc_dma_addr, o_desc_mem_addr,
        output o_resp_wready, o_cpl_valid, o_cpl_id, o_cpl_ch_sel, o_err
    );

    modport master (
        output i_req_valid, i_req_ctrl, i_req_dma_addr, i_req_mem_addr,
        output i_desc_rd, i_resp_wr, i_resp_desc_id, i_resp_ch_sel,
        input  o_req_ready, o_desc_rready, o_desc_endian, o_desc_write,
        input  o_desc_ch_sel, o_desc_len, o_desc_size, o_desc_burst, o_desc_sel,
        input  o_desc_id, o_desc_dma_addr, o_desc_mem_addr,
        input  o_resp_wready, o_cpl_valid, o_cpl_id, o_cpl_ch_sel, o_err
    );

endinterface

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter with eligibility mask; DMA_DESC_SCHED_PRIO_EN gives input 0 strict priority.
module dma_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     elig,
    input  logic             advance,
    output logic [N-1:0]     grant_c,
    output logic [IDX_W-1:0] grant_idx_c
);
`ifdef DMA_DESC_SCHED_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic [IDX_W-1:0] last_grant;

    // Search from last_grant+1 with wrap; input 0 is excluded from the rotation in priority mode
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        int unsigned      pos;
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        idx         = '0;
        pos         = 0;
        if (PRIO_EN && elig[0]) begin
            found      = 1'b1;
            grant_c[0] = 1'b1;
        end
        for (int unsigned k = 1; k <= N; k++) begin
            pos = 32'(last_grant) + k;
            if (pos >= N) pos = pos - N;
            idx = IDX_W'(pos);
            if (!found && elig[idx] && !(PRIO_EN && pos == 0)) begin
                found        = 1'b1;
                grant_c[idx] = 1'b1;
                grant_idx_c  = idx;
            end
        end
    end

    // Priority grants to input 0 leave the rotation pointer untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDX_W'(N - 1);
        end else if (advance && !(PRIO_EN && grant_c[0])) begin
            last_grant <= grant_idx_c;
        end
    end

endmodule

// File: rtl/dma_desc_scheduler.sv
// Descriptor scheduler: arbitrates requesters, tags and stages descriptors, routes completions.
// Optional build macro DMA_DESC_SCHED_PRIO_EN gives requester 0 strict priority.
module dma_desc_scheduler
    import dma_sched_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_OUT    = 4
) (
    input  logic                aclk,
    input  logic                anreset,
    input  logic                aenable,
    dma_desc_scheduler_if.slave bus
);
    localparam int unsigned REQ_W = $clog2(N_REQ);
    localparam int unsigned SEQ_W = DESC_ID_W - REQ_W;

    logic                  load_ok_c;
    logic                  accept_c;
    logic [N_REQ-1:0]      elig_c;
    logic [N_REQ-1:0]      grant_c;
    logic [REQ_W-1:0]      grant_idx_c;
    logic                  resp_fire_c;
    logic [REQ_W-1:0]      resp_req_c;
    logic [N_REQ-1:0]      resp_hit_c;
    logic                  cpl_ok_c;

    logic [CNT_W-1:0]      out_cnt [N_REQ];
    logic [SEQ_W-1:0]      seq     [N_REQ];

    logic                  stage_full;
    desc_ctrl_t            stage_ctrl;
    logic [DESC_ID_W-1:0]  stage_id;
    logic [ADDR_WIDTH-1:0] stage_dma_addr;
    logic [ADDR_WIDTH-1:0] stage_mem_addr;
    logic [N_REQ-1:0]      cpl_valid;
    logic [DESC_ID_W-1:0]  cpl_id;
    logic [1:0]            cpl_ch_sel;
    logic                  err;

    // Eligibility, stage availability and completion decode
    always_comb begin
        load_ok_c   = aenable && (!stage_full || bus.i_desc_rd);
        resp_fire_c = aenable && bus.i_resp_wr;
        resp_req_c  = bus.i_resp_desc_id[DESC_ID_W-1 -: REQ_W];
        elig_c      = '0;
        resp_hit_c  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            elig_c[i]     = bus.i_req_valid[i] && (out_cnt[i] < CNT_W'(MAX_OUT));
            resp_hit_c[i] = resp_fire_c && (resp_req_c == REQ_W'(i)) && (out_cnt[i] != '0);
        end
        cpl_ok_c = |resp_hit_c;
        accept_c = load_ok_c && (|grant_c);
    end

    dma_rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (REQ_W)
    ) u_arb (
        .clk         (aclk),
        .rst_n       (anreset),
        .elig        (elig_c),
        .advance     (accept_c),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    // Per-requester sequence and outstanding counters; issue and completion may net to zero
    always_ff @(posedge aclk or negedge anreset) begin
        if (!anreset) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                out_cnt[i] <= '0;
                seq[i]     <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                out_cnt[i] <= out_cnt[i] + CNT_W'(accept_c && grant_c[i]) - CNT_W'(resp_hit_c[i]);
                if (accept_c && grant_c[i]) seq[i] <= seq[i] + SEQ_W'(1);
            end
        end
    end

    // Single-entry output stage; holds while the DMA has not consumed it
    always_ff @(posedge aclk or negedge anreset) begin
        if (!anreset) begin
            stage_full     <= 1'b0;
            stage_ctrl     <= '0;
            stage_id       <= '0;
            stage_dma_addr <= '0;
            stage_mem_addr <= '0;
        end else if (load_ok_c) begin
            stage_full <= accept_c;
            if (accept_c) begin
                stage_ctrl     <= bus.i_req_ctrl[grant_idx_c];
                stage_id       <= {grant_idx_c, seq[grant_idx_c]};
                stage_dma_addr <= bus.i_req_dma_addr[grant_idx_c];
                stage_mem_addr <= bus.i_req_mem_addr[grant_idx_c];
            end
        end
    end

    // Completion pulse and sticky error for completions with nothing outstanding
    always_ff @(posedge aclk or negedge anreset) begin
        if (!anreset) begin
            cpl_valid  <= '0;
            cpl_id     <= '0;
            cpl_ch_sel <= '0;
            err        <= 1'b0;
        end else begin
            cpl_valid <= resp_hit_c;
            if (cpl_ok_c) begin
                cpl_id     <= bus.i_resp_desc_id;
                cpl_ch_sel <= bus.i_resp_ch_sel;
            end
            if (resp_fire_c && !cpl_ok_c) err <= 1'b1;
        end
    end

    assign bus.o_req_ready     = load_ok_c ? grant_c : '0;
    assign bus.o_resp_wready   = aenable;
    assign bus.o_desc_rready   = stage_full;
    assign bus.o_desc_endian   = stage_ctrl.endian;
    assign bus.o_desc_write    = stage_ctrl.write;
    assign bus.o_desc_ch_sel   = stage_ctrl.ch_sel;
    assign bus.o_desc_len      = stage_ctrl.len;
    assign bus.o_desc_size     = stage_ctrl.size;
    assign bus.o_desc_burst    = stage_ctrl.burst;
    assign bus.o_desc_sel      = stage_ctrl.sel;
    assign bus.o_desc_id       = stage_id;
    assign bus.o_desc_dma_addr = stage_dma_addr;
    assign bus.o_desc_mem_addr = stage_mem_addr;
    assign bus.o_cpl_valid     = cpl_valid;
    assign bus.o_cpl_id        = cpl_id;
    assign bus.o_cpl_ch_sel    = cpl_ch_sel;
    assign bus.o_err           = err;

endmodule

// File: tb/tb_dma_desc_scheduler.sv
// Randomized bench for dma_desc_scheduler against a queue-free behavioural model.
module tb_dma_desc_scheduler;
    import dma_sched_pkg::*;

    localparam int N_REQ   = 4;
    localparam int ADDR_W  = 16;
    localparam int MAX_OUT = 4;
    localparam int SEQ_W   = 6;

    logic aclk;
    logic anreset;
    logic aenable;

    dma_desc_scheduler_if #(.N_REQ(N_REQ), .ADDR_WIDTH(ADDR_W)) bus ();

    dma_desc_scheduler #(
        .N_REQ      (N_REQ),
        .ADDR_WIDTH (ADDR_W),
        .MAX_OUT    (MAX_OUT)
    ) dut (
        .aclk    (aclk),
        .anreset (anreset),
        .aenable (aenable),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Model state
    int          m_out [N_REQ];
    int          m_seq [N_REQ];
    int          m_last;
    bit          m_full;
    desc_ctrl_t  m_ctrl;
    logic [7:0]  m_id;
    logic [15:0] m_dma, m_mem;
    logic [3:0]  m_cpl;
    logic [7:0]  m_cpl_id;
    logic [1:0]  m_cpl_ch;
    bit          m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner = eligible requester closest after the last grant (requester 0 first in priority mode)
    function automatic int model_winner();
        int best, best_d, d;
        best = -1;
        best_d = N_REQ + 1;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.i_req_valid[i] && m_out[i] < MAX_OUT) begin
`ifdef DMA_DESC_SCHED_PRIO_EN
                if (i == 0) return 0;
`endif
                d = (i - m_last - 1 + 2 * N_REQ) % N_REQ;
                if (d < best_d) begin
                    best_d = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic set_idle();
        for (int i = 0; i < N_REQ; i++) begin
            bus.i_req_valid[i]    = 1'b0;
            bus.i_req_ctrl[i]     = '0;
            bus.i_req_dma_addr[i] = '0;
            bus.i_req_mem_addr[i] = '0;
        end
        bus.i_desc_rd      = 1'b0;
        bus.i_resp_wr      = 1'b0;
        bus.i_resp_desc_id = '0;
        bus.i_resp_ch_sel  = '0;
    endtask

    task automatic do_reset();
        anreset = 1'b0;
        aenable = 1'b0;
        set_idle();
        for (int i = 0; i < N_REQ; i++) begin
            m_out[i] = 0;
            m_seq[i] = 0;
        end
        m_last = N_REQ - 1;
        m_full = 0;
        m_cpl  = '0;
        m_err  = 0;
        #2;
        chk("rst_rready", 64'(bus.o_desc_rready), 64'(0));
        chk("rst_id", 64'(bus.o_desc_id), 64'(0));
        chk("rst_cpl_valid", 64'(bus.o_cpl_valid), 64'(0));
        chk("rst_err", 64'(bus.o_err), 64'(0));
        chk("rst_wready", 64'(bus.o_resp_wready), 64'(0));
        chk("rst_req_ready", 64'(bus.o_req_ready), 64'(0));
        @(posedge aclk);
        #1;
        anreset = 1'b1;
        aenable = 1'b1;
    endtask

    // Check all outputs against the model for the current inputs, then advance the model one edge
    task automatic step();
        int w, r;
        bit lok, fire, ok;
        logic [3:0] exp_rdy;
        #1;
        chk("rready", 64'(bus.o_desc_rready), 64'(m_full));
        if (m_full) begin
            chk("desc_id", 64'(bus.o_desc_id), 64'(m_id));
            chk("desc_ctrl", 64'({bus.o_desc_endian, bus.o_desc_write, bus.o_desc_ch_sel, bus.o_desc_len,
                                  bus.o_desc_size, bus.o_desc_burst, bus.o_desc_sel}), 64'(m_ctrl));
            chk("desc_dma", 64'(bus.o_desc_dma_addr), 64'(m_dma));
            chk("desc_mem", 64'(bus.o_desc_mem_addr), 64'(m_mem));
        end
        chk("cpl_valid", 64'(bus.o_cpl_valid), 64'(m_cpl));
        if (m_cpl != 0) begin
            chk("cpl_id", 64'(bus.o_cpl_id), 64'(m_cpl_id));
            chk("cpl_ch", 64'(bus.o_cpl_ch_sel), 64'(m_cpl_ch));
        end
        chk("err", 64'(bus.o_err), 64'(m_err));
        chk("wready", 64'(bus.o_resp_wready), 64'(aenable));
        lok = aenable && (!m_full || bus.i_desc_rd);
        w = model_winner();
        exp_rdy = (lok && w >= 0) ? 4'(1 << w) : 4'b0;
        chk("req_ready", 64'(bus.o_req_ready), 64'(exp_rdy));

        fire = aenable && bus.i_resp_wr;
        r = int'(bus.i_resp_desc_id) >> SEQ_W;
        ok = fire && m_out[r] > 0;
        m_cpl = ok ? 4'(1 << r) : 4'b0;
        if (ok) begin
            m_cpl_id = bus.i_resp_desc_id;
            m_cpl_ch = bus.i_resp_ch_sel;
            m_out[r]--;
        end
        if (fire && !ok) m_err = 1;
        if (lok) begin
            m_full = (w >= 0);
            if (w >= 0) begin
                m_ctrl = bus.i_req_ctrl[w];
                m_dma  = bus.i_req_dma_addr[w];
                m_mem  = bus.i_req_mem_addr[w];
                m_id   = 8'(w * 64 + m_seq[w]);
                m_seq[w] = (m_seq[w] + 1) % 64;
                m_out[w]++;
`ifdef DMA_DESC_SCHED_PRIO_EN
                if (w != 0) m_last = w;
`else
                m_last = w;
`endif
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic rand_inputs(input bit bad_ok);
        int r;
        aenable = ($urandom_range(0, 9) != 0);
        for (int i = 0; i < N_REQ; i++) begin
            bus.i_req_valid[i]    = ($urandom_range(0, 2) != 0);
            bus.i_req_ctrl[i]     = desc_ctrl_t'(DESC_CTRL_W'($urandom));
            bus.i_req_dma_addr[i] = 16'($urandom);
            bus.i_req_mem_addr[i] = 16'($urandom);
        end
        bus.i_desc_rd = ($urandom_range(0, 3) != 0);
        bus.i_resp_wr = 1'b0;
        r = int'($urandom_range(0, N_REQ - 1));
        if ($urandom_range(0, 1) == 1 && (m_out[r] > 0 || (bad_ok && $urandom_range(0, 15) == 0))) begin
            bus.i_resp_wr      = 1'b1;
            bus.i_resp_desc_id = {2'(r), 6'($urandom)};
            bus.i_resp_ch_sel  = 2'($urandom);
        end
    endtask

    logic [7:0] exp_ids [5];

    initial begin
        anreset = 1'b0;
        aenable = 1'b0;
        set_idle();

        // Single requester: first accept, latency and id sequence
        do_reset();
        bus.i_req_valid[0]    = 1'b1;
        bus.i_req_ctrl[0]     = desc_ctrl_t'(DESC_CTRL_W'(8) << LEN_LSB);
        bus.i_req_dma_addr[0] = 16'h0100;
        bus.i_req_mem_addr[0] = 16'h2000;
        bus.i_desc_rd         = 1'b1;
        #1;
        chk("t1_ready0", 64'(bus.o_req_ready), 64'(4'b0001));
        step();
        chk("t1_rready", 64'(bus.o_desc_rready), 64'(1));
        chk("t1_id0", 64'(bus.o_desc_id), 64'(8'h00));
        chk("t1_dma", 64'(bus.o_desc_dma_addr), 64'(16'h0100));
        chk("t1_len", 64'(bus.o_desc_len), 64'(8));
        step();
        chk("t1_id1", 64'(bus.o_desc_id), 64'(8'h01));
        bus.i_req_valid[0] = 1'b0;
        step();
        step();

        // All requesters valid: rotation order and ids
        do_reset();
`ifdef DMA_DESC_SCHED_PRIO_EN
        exp_ids = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h40};
`else
        exp_ids = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h01};
`endif
        bus.i_req_valid = 4'b1111;
        bus.i_desc_rd   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_id", 64'(bus.o_desc_id), 64'(exp_ids[k]));
        end

        // Outstanding limit, completion re-enables the requester
        do_reset();
        bus.i_req_valid = 4'b0010;
        bus.i_desc_rd   = 1'b1;
        for (int k = 0; k < 4; k++) step();
        bus.i_req_valid    = 4'b0110;
        bus.i_resp_wr      = 1'b1;
        bus.i_resp_desc_id = 8'h40;
        bus.i_resp_ch_sel  = 2'd3;
        #1;
        chk("t3_skip_full", 64'(bus.o_req_ready), 64'(4'b0100));
        step();
        chk("t3_cpl_valid", 64'(bus.o_cpl_valid), 64'(4'b0010));
        chk("t3_cpl_id", 64'(bus.o_cpl_id), 64'(8'h40));
        chk("t3_cpl_ch", 64'(bus.o_cpl_ch_sel), 64'(2'd3));
        bus.i_resp_wr = 1'b0;
        #1;
        chk("t3_req1_back", 64'(bus.o_req_ready), 64'(4'b0010));
        step();

        // Stall: stage full with no read
        bus.i_req_valid = 4'b1111;
        bus.i_desc_rd   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_stall_ready", 64'(bus.o_req_ready), 64'(0));
            step();
        end
        bus.i_desc_rd = 1'b1;
        #1;
        chk("t4_resume", 64'(bus.o_req_ready != 0), 64'(1));
        step();

        // Completion for a requester with nothing outstanding
        do_reset();
        bus.i_resp_wr      = 1'b1;
        bus.i_resp_desc_id = 8'hC5;
        step();
        chk("t5_no_cpl", 64'(bus.o_cpl_valid), 64'(0));
        chk("t5_err", 64'(bus.o_err), 64'(1));
        bus.i_resp_wr = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("t5_err_sticky", 64'(bus.o_err), 64'(1));

        // Same-cycle issue and completion on requester 2
        do_reset();
        bus.i_req_valid = 4'b0100;
        bus.i_desc_rd   = 1'b1;
        step();
        step();
        bus.i_resp_wr      = 1'b1;
        bus.i_resp_desc_id = 8'h80;
        step();
        bus.i_resp_wr = 1'b0;
        step();
        step();
        #1;
        chk("t6_limit_after_net0", 64'(bus.o_req_ready), 64'(0));
        step();

        // Randomized traffic, with a mid-run reset and later some stray completions
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if (k == 700) do_reset();
            rand_inputs(1'b0);
            step();
        end
        for (int k = 0; k < 1500; k++) begin
            rand_inputs(1'b1);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
